// File: rtl/ccw_pkg.sv
// Shared definitions for the CCW link: receiver state encoding, length-field geometry
// and the length-byte validity rule used by both the receiver and the generator rework.
package ccw_pkg;

    localparam int         CCW_LEN_W    = 6;
    localparam logic [7:0] CCW_LEN_MASK = 8'hC0;

    typedef enum logic [1:0] {
        CCW_RX_IDLE,
        CCW_RX_DATA,
        CCW_RX_FLUSH,
        CCW_RX_RESP
    } ccw_rx_state_e;

    // A length byte is usable only if the reserved top bits are clear and it names the configured length.
    function automatic logic ccw_len_byte_ok(input logic [7:0]           len_byte,
                                             input logic [CCW_LEN_W-1:0] cfg_len);
        return ((len_byte & CCW_LEN_MASK) == 8'h00) && (len_byte[CCW_LEN_W-1:0] == cfg_len);
    endfunction

endpackage

// File: rtl/ccw_gap_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and flags expiry
// once the count reaches GAP_CYC-1, holding there until cleared.
module ccw_gap_timer #(
    parameter int GAP_CYC = 1024
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TW-1:0] LIMIT = TW'(GAP_CYC - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign expired = (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ccw_rcv.sv
// CCW link receiver: parses length byte plus L+1 counting payload bytes, streams the
// payload, and answers each frame with a registered accept or repeat-request pulse.
module ccw_rcv
    import ccw_pkg::*;
#(
    parameter int GAP_CYC = 1024,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [CCW_LEN_W-1:0] ccw_len,
    input  logic [7:0]           rx_d,
    input  logic                 rx_d_vld,
    input  logic                 rx_err,
    output logic [7:0]           pay_d,
    output logic                 pay_vld,
    output logic                 ccw_accepted,
    output logic                 ccw_repeat_req,
    output logic                 rx_busy,
    output logic [CCW_LEN_W-1:0] last_len,
    output logic [CNT_W-1:0]     err_cnt
);

    ccw_rx_state_e        state_q, state_d;
    logic [CCW_LEN_W-1:0] len_q, len_d;
    logic [CCW_LEN_W-1:0] exp_q, exp_d;
    logic [7:0]           pay_d_q, pay_d_d;
    logic                 pay_vld_q, pay_vld_d;
    logic                 accepted_q, accepted_d;
    logic                 repeat_q, repeat_d;
    logic [CCW_LEN_W-1:0] last_len_q, last_len_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    // The timer only runs while a frame is open; outside DATA/FLUSH it is held at zero.
    assign timer_enable = (state_q == CCW_RX_DATA) || (state_q == CCW_RX_FLUSH);
    assign timer_clear  = rx_d_vld || !timer_enable;

    ccw_gap_timer #(
        .GAP_CYC (GAP_CYC)
    ) u_gap_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        exp_d      = exp_q;
        pay_d_d    = pay_d_q;
        pay_vld_d  = 1'b0;
        accepted_d = 1'b0;
        repeat_d   = 1'b0;
        last_len_d = last_len_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            // RESP lasts one cycle but already accepts the next frame's length byte.
            CCW_RX_IDLE, CCW_RX_RESP: begin
                state_d = CCW_RX_IDLE;
                if (rx_d_vld) begin
                    if (!rx_err && ccw_len_byte_ok(rx_d, ccw_len)) begin
                        len_d   = rx_d[CCW_LEN_W-1:0];
                        exp_d   = '0;
                        state_d = CCW_RX_DATA;
                    end else begin
                        state_d = CCW_RX_FLUSH;
                    end
                end
            end

            CCW_RX_DATA: begin
                if (rx_d_vld) begin
                    pay_d_d   = rx_d;
                    pay_vld_d = 1'b1;
                    if (!rx_err && (rx_d == {2'b00, exp_q})) begin
                        if (exp_q == len_q) begin
                            accepted_d = 1'b1;
                            last_len_d = len_q;
                            state_d    = CCW_RX_RESP;
                        end else begin
                            exp_d = exp_q + CCW_LEN_W'(1);
                        end
                    end else begin
                        state_d = CCW_RX_FLUSH;
                    end
                end else if (timer_expired) begin
                    repeat_d = 1'b1;
                    state_d  = CCW_RX_RESP;
                end
            end

            CCW_RX_FLUSH: begin
                if (!rx_d_vld && timer_expired) begin
                    repeat_d = 1'b1;
                    state_d  = CCW_RX_RESP;
                end
            end

            default: begin
                state_d = CCW_RX_IDLE;
            end
        endcase

        if (repeat_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= CCW_RX_IDLE;
            len_q      <= '0;
            exp_q      <= '0;
            pay_d_q    <= '0;
            pay_vld_q  <= 1'b0;
            accepted_q <= 1'b0;
            repeat_q   <= 1'b0;
            last_len_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            exp_q      <= exp_d;
            pay_d_q    <= pay_d_d;
            pay_vld_q  <= pay_vld_d;
            accepted_q <= accepted_d;
            repeat_q   <= repeat_d;
            last_len_q <= last_len_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign pay_d          = pay_d_q;
    assign pay_vld        = pay_vld_q;
    assign ccw_accepted   = accepted_q;
    assign ccw_repeat_req = repeat_q;
    assign rx_busy        = (state_q != CCW_RX_IDLE);
    assign last_len       = last_len_q;
    assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_ccw_rcv.sv
// Directed bench for ccw_rcv: good frames, bad payload, bad length, timeouts,
// back-to-back length byte in RESP, error-counter saturation and mid-frame reset.
module tb_ccw_rcv;

    localparam int GAP = 32;

    logic       clk;
    logic       n_rst;
    logic [5:0] ccw_len;
    logic [7:0] rx_d;
    logic       rx_d_vld;
    logic       rx_err;
    logic [7:0] pay_d;
    logic       pay_vld;
    logic       ccw_accepted;
    logic       ccw_repeat_req;
    logic       rx_busy;
    logic [5:0] last_len;
    logic [7:0] err_cnt;

    int checkCount = 0;
    int failCount  = 0;
    int accSeen    = 0;
    int repSeen    = 0;
    int paySeen    = 0;

    ccw_rcv #(
        .GAP_CYC (GAP),
        .CNT_W   (8)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .ccw_len        (ccw_len),
        .rx_d           (rx_d),
        .rx_d_vld       (rx_d_vld),
        .rx_err         (rx_err),
        .pay_d          (pay_d),
        .pay_vld        (pay_vld),
        .ccw_accepted   (ccw_accepted),
        .ccw_repeat_req (ccw_repeat_req),
        .rx_busy        (rx_busy),
        .last_len       (last_len),
        .err_cnt        (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (ccw_accepted === 1'b1)   accSeen++;
        if (ccw_repeat_req === 1'b1) repSeen++;
        if (pay_vld === 1'b1)        paySeen++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; drives one byte for one cycle and returns at the next negedge.
    task automatic applyStimulus(input logic [7:0] b, input logic e);
        rx_d     = b;
        rx_err   = e;
        rx_d_vld = 1'b1;
        @(negedge clk);
        rx_d_vld = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends a full good frame back-to-back and checks every payload strobe and the accept.
    task automatic sendFrame(input string tag, input logic [5:0] len);
        applyStimulus({2'b00, len}, 1'b0);
        checkOutput({tag, "_lenpay"}, pay_vld, 1'b0);
        for (int i = 0; i <= int'(len); i++) begin
            applyStimulus(8'(i), 1'b0);
            checkOutput({tag, "_pay_d"}, pay_d, 8'(i));
            checkOutput({tag, "_acc"}, ccw_accepted, (i == int'(len)) ? 1'b1 : 1'b0);
        end
        checkOutput({tag, "_last_len"}, last_len, len);
        @(negedge clk);
        checkOutput({tag, "_idle"}, rx_busy, 1'b0);
    endtask

    // After the last byte, the repeat pulse lands exactly GAP cycles later and busy drops right after.
    task automatic quietAndRepeat(input string tag);
        idleCycles(GAP - 1);
        checkOutput({tag, "_early"}, ccw_repeat_req, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_rep"}, ccw_repeat_req, 1'b1);
        checkOutput({tag, "_acc0"}, ccw_accepted, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_busy0"}, rx_busy, 1'b0);
        checkOutput({tag, "_rep0"}, ccw_repeat_req, 1'b0);
    endtask

    initial begin
        n_rst    = 1'b0;
        ccw_len  = 6'd0;
        rx_d     = 8'h00;
        rx_d_vld = 1'b0;
        rx_err   = 1'b0;
        idleCycles(2);
        checkOutput("rst_pay_vld", pay_vld, 1'b0);
        checkOutput("rst_pay_d", pay_d, 8'h00);
        checkOutput("rst_pulses", {ccw_accepted, ccw_repeat_req, rx_busy}, 3'b000);
        checkOutput("rst_last_len", last_len, 6'd0);
        checkOutput("rst_err_cnt", err_cnt, 8'd0);
        n_rst = 1'b1;
        @(negedge clk);

        $display("[TB] test 1: spaced good frame L=3");
        ccw_len = 6'd3;
        applyStimulus(8'h03, 1'b0);
        checkOutput("t1_busy", rx_busy, 1'b1);
        checkOutput("t1_lenpay", pay_vld, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idleCycles(4);
            applyStimulus(8'(i), 1'b0);
            checkOutput("t1_pay_vld", pay_vld, 1'b1);
            checkOutput("t1_pay_d", pay_d, 8'(i));
            checkOutput("t1_acc", ccw_accepted, (i == 3) ? 1'b1 : 1'b0);
        end
        checkOutput("t1_last_len", last_len, 6'd3);
        @(negedge clk);
        checkOutput("t1_acc_one", ccw_accepted, 1'b0);
        checkOutput("t1_idle", rx_busy, 1'b0);

        $display("[TB] test 2: bad payload then flush timeout");
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("t2_pay0", pay_d, 8'h00);
        applyStimulus(8'h05, 1'b0);
        checkOutput("t2_badvld", pay_vld, 1'b1);
        checkOutput("t2_bad_d", pay_d, 8'h05);
        checkOutput("t2_noacc", ccw_accepted, 1'b0);
        applyStimulus(8'h02, 1'b0);
        checkOutput("t2_flushvld", pay_vld, 1'b0);
        quietAndRepeat("t2");
        checkOutput("t2_err", err_cnt, 8'd1);

        $display("[TB] test 3: bad length byte then good frame");
        applyStimulus(8'h04, 1'b0);
        checkOutput("t3_nopay", pay_vld, 1'b0);
        checkOutput("t3_busy", rx_busy, 1'b1);
        quietAndRepeat("t3");
        checkOutput("t3_err", err_cnt, 8'd2);
        sendFrame("t3f", 6'd3);

        $display("[TB] test 4: truncated frame L=2");
        ccw_len = 6'd2;
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h00, 1'b0);
        quietAndRepeat("t4");
        checkOutput("t4_err", err_cnt, 8'd3);
        checkOutput("t4_last_len", last_len, 6'd3);

        $display("[TB] test 5: L=0 frames, length byte during RESP");
        ccw_len = 6'd0;
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("t5_acc1", ccw_accepted, 1'b1);
        checkOutput("t5_last_len", last_len, 6'd0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("t5_resp_len", {rx_busy, ccw_accepted, pay_vld}, 3'b100);
        ccw_len = 6'd7;
        applyStimulus(8'h00, 1'b0);
        checkOutput("t5_acc2", ccw_accepted, 1'b1);
        @(negedge clk);
        checkOutput("t5_acc_total", accSeen, 32'd4);

        $display("[TB] test 6: rx_err payload, counter saturation, mid-frame reset");
        ccw_len = 6'd2;
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h01, 1'b1);
        checkOutput("t6_errbyte_d", {pay_vld, pay_d}, 9'h101);
        quietAndRepeat("t6");
        checkOutput("t6_err", err_cnt, 8'd4);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(8'hFF, 1'b0);
            idleCycles(GAP + 1);
        end
        checkOutput("t6_sat", err_cnt, 8'd255);
        checkOutput("t6_rep_total", repSeen, 32'd304);

        ccw_len = 6'd3;
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("t6_pre_rst", pay_vld, 1'b1);
        n_rst = 1'b0;
        #1;
        checkOutput("t6_rst_outs", {pay_vld, ccw_accepted, ccw_repeat_req, rx_busy}, 4'b0000);
        checkOutput("t6_rst_regs", {pay_d, last_len, err_cnt}, 22'd0);
        @(negedge clk);
        n_rst = 1'b1;
        idleCycles(GAP + 4);
        checkOutput("t6_no_pulse", {accSeen[15:0], repSeen[15:0]}, {16'd4, 16'd304});
        sendFrame("t6f", 6'd3);
        checkOutput("t6_pay_total", paySeen, 32'd20);

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
